gf180mcu_ocd_io__bi_ctrl: RTL



---
 rtl/gf180mcu_ocd_io_pkg.sv | 47 ++++
 rtl/gf180mcu_ocd_io__in_filt.sv | 48 ++++
 rtl/gf180mcu_ocd_io__bi_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gf180mcu_ocd_io_pkg.sv
// Shared definitions for the gf180mcu_ocd_io bidirectional pad bank controller.
//   - bit positions inside the per-pad config byte
//   - reset value of every config byte (pulled down, everything else off)
//   - commit sequencer states
//   - packed view of a config byte and the PU/PD conflict resolver
package gf180mcu_ocd_io_pkg;

  localparam int CFG_OE    = 0;
  localparam int CFG_IE    = 1;
  localparam int CFG_PU    = 2;
  localparam int CFG_PD    = 3;
  localparam int CFG_CS    = 4;
  localparam int CFG_SL    = 5;
  localparam int CFG_PDRV0 = 6;
  localparam int CFG_PDRV1 = 7;

  localparam logic [7:0] CFG_RST = 8'h08;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    APPLY,
    ENABLE,
    DONE
  } bi_state_e;

  // Field order mirrors the byte layout: oe is bit 0, pdrv1 is bit 7.
  typedef struct packed {
    logic pdrv1;
    logic pdrv0;
    logic sl;
    logic cs;
    logic pd;
    logic pu;
    logic ie;
    logic oe;
  } pad_cfg_t;

  // Pull-up and pull-down together would fight in the pad; pull-up wins.
  function automatic logic [7:0] cfg_sanitize(input logic [7:0] w);
    logic [7:0] r;
    r = w;
    if (w[CFG_PU] && w[CFG_PD]) r[CFG_PD] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__in_filt.sv
// Single-bit input conditioner: SYNC_STAGES-flop synchroniser followed by a
// persistence filter. q only follows the synchronised value once it has
// differed from q for FILT_LEN consecutive cycles; FILT_LEN=1 makes q a plain
// one-cycle-delayed copy of the synchroniser output.
// Ports:
//   clk, rst_n : bank clock, async active-low reset
//   d          : asynchronous input (already gated by IE)
//   q          : filtered, clock-domain-safe output
module gf180mcu_ocd_io__in_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
  end

  // The counter tracks how long s has disagreed with q. The edge that would
  // take it to FILT_LEN flips q instead, and the count restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (s == q) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      cnt <= '0;
      q   <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gf180mcu_ocd_io__bi_ctrl.sv
// Core-side controller for a bank of NPADS bidirectional bi_t pad cells.
// Per-pad config is written into shadow registers and moved into the active
// registers by a commit sequence that keeps OE low on every pad being
// reconfigured until its pulls/drive/slew are already at their new values.
// Ports:
//   clk, rst_n          : bank clock, async active-low reset
//   cfg_we/addr/wdata   : shadow write port (ignored while busy or out of range)
//   cfg_rdata           : registered shadow readback at cfg_addr
//   commit, busy, done  : apply request, sequence active, completion pulse
//   core_a -> pad_a     : output data, combinational pass-through
//   pad_y -> core_y     : IE-gated, synchronised, filtered input data
//   pad_oe..pad_pdrv1   : per-pad config to the pad cells
module gf180mcu_ocd_io__bi_ctrl
  import gf180mcu_ocd_io_pkg::*;
#(
  parameter int NPADS       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int QUIESCE_CYC = 2,
  parameter int AW          = (NPADS > 1) ? $clog2(NPADS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  input  logic             commit,
  output logic             busy,
  output logic             done,
  input  logic [NPADS-1:0] core_a,
  output logic [NPADS-1:0] core_y,
  output logic [NPADS-1:0] pad_a,
  output logic [NPADS-1:0] pad_oe,
  output logic [NPADS-1:0] pad_ie,
  output logic [NPADS-1:0] pad_pu,
  output logic [NPADS-1:0] pad_pd,
  output logic [NPADS-1:0] pad_cs,
  output logic [NPADS-1:0] pad_sl,
  output logic [NPADS-1:0] pad_pdrv0,
  output logic [NPADS-1:0] pad_pdrv1,
  input  logic [NPADS-1:0] pad_y
);

  logic [NPADS-1:0][7:0] shadow;
  logic [NPADS-1:0][7:0] active;
  logic [NPADS-1:0]      chg;
  logic [3:0]            qcnt;
  bi_state_e             state, nstate;
  logic                  in_range, wr_en, force_oe, start;
  logic [7:0]            wbyte, rd_next;

  assign in_range = (32'(cfg_addr) < 32'(NPADS));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign wr_en    = cfg_we & ~busy & in_range;
  assign start    = (state == IDLE) & commit;
  assign wbyte    = cfg_sanitize(cfg_wdata);
  // OE stays forced until the edge that loads the new OE, so a pad never
  // drives while its other settings are still in flux.
  assign force_oe = (state == QUIESCE) | (state == APPLY) | (state == ENABLE);

  // ---------------- shadow registers + readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     shadow <= {NPADS{CFG_RST}};
    else if (wr_en) shadow[cfg_addr] <= wbyte;
  end

  // Bypass the write data so the new byte is visible right after the write edge.
  always_comb begin
    rd_next = '0;
    if (in_range) rd_next = wr_en ? wbyte : shadow[cfg_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_rdata <= '0;
    else        cfg_rdata <= rd_next;
  end

  // ---------------- commit sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (commit) nstate = QUIESCE;
      QUIESCE: if (qcnt == 4'(QUIESCE_CYC - 1)) nstate = APPLY;
      APPLY:   nstate = ENABLE;
      ENABLE:  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Changing-pad mask is frozen at commit; shadows cannot move while busy,
  // so it stays consistent with what APPLY/ENABLE will load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt <= '0;
      chg  <= '0;
    end else if (start) begin
      qcnt <= '0;
      for (int i = 0; i < NPADS; i++) chg[i] <= (shadow[i] != active[i]);
    end else if (state == QUIESCE) begin
      qcnt <= qcnt + 4'd1;
    end
  end

  // Non-OE bits land one cycle ahead of OE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= {NPADS{CFG_RST}};
    end else begin
      for (int i = 0; i < NPADS; i++) begin
        if (chg[i] && state == APPLY)
          active[i][CFG_PDRV1:CFG_IE] <= shadow[i][CFG_PDRV1:CFG_IE];
        if (chg[i] && state == ENABLE)
          active[i][CFG_OE] <= shadow[i][CFG_OE];
      end
    end
  end

  // ---------------- per-pad fan-out and input conditioning
  assign pad_a = core_a;

  for (genvar i = 0; i < NPADS; i++) begin : g_pad
    pad_cfg_t ac;
    assign ac           = pad_cfg_t'(active[i]);
    assign pad_oe[i]    = ac.oe & ~(force_oe & chg[i]);
    assign pad_ie[i]    = ac.ie;
    assign pad_pu[i]    = ac.pu;
    assign pad_pd[i]    = ac.pd;
    assign pad_cs[i]    = ac.cs;
    assign pad_sl[i]    = ac.sl;
    assign pad_pdrv0[i] = ac.pdrv0;
    assign pad_pdrv1[i] = ac.pdrv1;

    gf180mcu_ocd_io__in_filt #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_y[i] & ac.ie),
      .q     (core_y[i])
    );
  end

endmodule
